// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave servicing write/read bursts from a single-port synchronous SRAM
module axi_sram_slave #(
   parameter int ID_WIDTH   = 10,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_AW     = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [MEM_AW-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int OFF = $clog2(DATA_WIDTH/8);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA, RRESP} state_t;

   state_t                  state, state_nx;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [1:0]              resp_q;
   logic                    err_q;
   logic                    prio_wr_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    rlast_q;

   logic                    grant_wr, grant_rd;
   logic                    last_beat;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [1:0]              sel_burst;
   logic [1:0]              accept_resp;

   assign last_beat = (beat_q == len_q);
   assign next_addr = (burst_q == BURST_INCR) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
   assign sel_addr  = grant_wr ? s_axi_awaddr  : s_axi_araddr;
   assign sel_burst = grant_wr ? s_axi_awburst : s_axi_arburst;

   // Classify the request being granted: bad burst type first, then range.
   always_comb begin
      accept_resp = RESP_OKAY;
      if (sel_burst != BURST_FIXED && sel_burst != BURST_INCR)
         accept_resp = RESP_SLVERR;
      else if (|sel_addr[ADDR_WIDTH-1:MEM_AW+OFF])
         accept_resp = RESP_DECERR;
   end

   assign mem_addr     = addr_q[MEM_AW+OFF-1:OFF];
   assign mem_wdata    = s_axi_wdata;
   assign mem_wstrb    = s_axi_wstrb;
   assign s_axi_bvalid = (state == WRESP);
   assign s_axi_bid    = id_q;
   assign s_axi_bresp  = resp_q;
   assign s_axi_rvalid = (state == RRESP);
   assign s_axi_rid    = id_q;
   assign s_axi_rresp  = resp_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rlast  = rlast_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state, arbitration grants, handshake readies and SRAM strobes.
   always_comb begin
      state_nx      = state;
      grant_wr      = 1'b0;
      grant_rd      = 1'b0;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_wready  = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      case (state)
         IDLE: begin
            if (s_axi_awvalid && s_axi_arvalid) begin
               grant_wr = prio_wr_q;
               grant_rd = !prio_wr_q;
            end else begin
               grant_wr = s_axi_awvalid;
               grant_rd = s_axi_arvalid;
            end
            s_axi_awready = grant_wr;
            s_axi_arready = grant_rd;
            if (grant_wr)      state_nx = WDATA;
            else if (grant_rd) state_nx = RADDR;
         end
         WDATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid) begin
               mem_req = !err_q;
               mem_we  = !err_q;
               if (last_beat) state_nx = WRESP;
            end
         end
         WRESP: begin
            if (s_axi_bready) state_nx = IDLE;
         end
         RADDR: begin
            mem_req  = !err_q;
            state_nx = RDATA;
         end
         RDATA: begin
            state_nx = RRESP;
         end
         RRESP: begin
            if (s_axi_rready) state_nx = last_beat ? IDLE : RADDR;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Burst context, beat counting, response tracking and the read output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_wr_q <= 1'b1;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         resp_q    <= RESP_OKAY;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         if (state == IDLE && s_axi_awvalid && s_axi_arvalid)
            prio_wr_q <= !prio_wr_q;
         if (grant_wr || grant_rd) begin
            id_q    <= grant_wr ? s_axi_awid    : s_axi_arid;
            addr_q  <= sel_addr;
            len_q   <= grant_wr ? s_axi_awlen   : s_axi_arlen;
            size_q  <= grant_wr ? s_axi_awsize  : s_axi_arsize;
            burst_q <= sel_burst;
            beat_q  <= '0;
            resp_q  <= accept_resp;
            err_q   <= (accept_resp != RESP_OKAY);
         end
         if (state == WDATA && s_axi_wvalid) begin
            if (s_axi_wlast != last_beat) resp_q <= RESP_SLVERR;
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr;
         end
         if (state == RDATA) begin
            rdata_q <= err_q ? '0 : mem_rdata;
            rlast_q <= last_beat;
         end
         if (state == RRESP && s_axi_rready) begin
            beat_q  <= beat_q + 8'd1;
            addr_q  <= next_addr;
            rlast_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed table-driven bench for axi_sram_slave
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  awid = '0, arid = '0, bid, rid;
   logic [63:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
   logic        awvalid = 1'b0, arvalid = 1'b0, awready, arready;
   logic [63:0] wdata = '0, rdata;
   logic [7:0]  wstrb = '0;
   logic        wlast = 1'b0, wvalid = 1'b0, wready;
   logic        bvalid, bready = 1'b0;
   logic        rlast, rvalid, rready = 1'b0;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata = '0;
   logic [7:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   axi_sram_slave dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              wr;
      logic [9:0]      id;
      logic [63:0]     addr;
      logic [7:0]      len;
      logic [2:0]      size;
      logic [1:0]      burst;
      logic [7:0]      s0, s1;
      bit              bad_wlast;
      logic [1:0]      resp;
      int              nreq;
      logic [3:0][11:0] w;
      logic [3:0][63:0] d;
   } vec_t;

   typedef struct {
      logic [11:0] a;
      logic        we;
      logic [63:0] d;
      logic [7:0]  s;
   } mreq_t;

   mreq_t       mq[$];
   logic [63:0] sram [0:4095];

   // SRAM model: byte-strobed writes, one-cycle read latency; logs every request.
   always @(posedge clk) begin
      if (mem_req) begin
         mq.push_back('{a: mem_addr, we: mem_we, d: mem_wdata, s: mem_wstrb});
         if (mem_we) begin
            for (int b = 0; b < 8; b++)
               if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic wait_hi(input int which, input string nm);
      bit got = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         case (which)
            0: got = awready;
            1: got = arready;
            2: got = wready;
            3: got = bvalid;
            default: got = rvalid;
         endcase
      end
      if (!got) chk({"timeout_", nm}, 64'd0, 64'd1);
   endtask

   function automatic vec_t mk(bit wr, logic [9:0] id, logic [63:0] a, logic [7:0] l,
                               logic [2:0] s, logic [1:0] b, logic [7:0] s0, logic [7:0] s1,
                               bit bad, logic [1:0] resp, int n,
                               logic [11:0] w0, logic [11:0] w1, logic [11:0] w2, logic [11:0] w3,
                               logic [63:0] d0, logic [63:0] d1, logic [63:0] d2, logic [63:0] d3);
      vec_t v;
      v.wr = wr; v.id = id; v.addr = a; v.len = l; v.size = s; v.burst = b;
      v.s0 = s0; v.s1 = s1; v.bad_wlast = bad; v.resp = resp; v.nreq = n;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      return v;
   endfunction

   task automatic set_aw(input vec_t v);
      awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
   endtask

   task automatic set_ar(input vec_t v);
      arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
   endtask

   task automatic w_phase(input vec_t v);
      for (int i = 0; i <= int'(v.len); i++) begin
         wdata  = v.d[i];
         wstrb  = i[0] ? v.s1 : v.s0;
         wlast  = v.bad_wlast ? (i == 0) : (i == int'(v.len));
         wvalid = 1'b1;
         wait_hi(2, "wready");
         @(posedge clk); #1;
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      bready = 1'b1;
      wait_hi(3, "bvalid");
      chk("bresp", 64'(bresp), 64'(v.resp));
      chk("bid", 64'(bid), 64'(v.id));
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic r_phase(input vec_t v);
      for (int i = 0; i <= int'(v.len); i++) begin
         wait_hi(4, "rvalid");
         chk($sformatf("rdata%0d", i), rdata, v.d[i]);
         chk($sformatf("rlast%0d", i), 64'(rlast), 64'(i == int'(v.len)));
         chk("rresp", 64'(rresp), 64'(v.resp));
         chk("rid", 64'(rid), 64'(v.id));
         @(posedge clk); #1;
         @(negedge clk);
         chk("rvalid_hold", 64'(rvalid), 64'd1);
         chk("rdata_hold", rdata, v.d[i]);
         chk("rlast_hold", 64'(rlast), 64'(i == int'(v.len)));
         @(posedge clk); #1 rready = 1'b1;
         @(posedge clk); #1 rready = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int base = mq.size();
      if (v.wr) begin
         set_aw(v); awvalid = 1'b1;
         wait_hi(0, "awready");
         @(posedge clk); #1 awvalid = 1'b0;
         w_phase(v);
      end else begin
         set_ar(v); arvalid = 1'b1;
         wait_hi(1, "arready");
         @(posedge clk); #1 arvalid = 1'b0;
         r_phase(v);
      end
      chk($sformatf("v%0d_nreq", k), 64'(mq.size() - base), 64'(v.nreq));
      for (int i = 0; i < v.nreq && base + i < mq.size(); i++) begin
         chk($sformatf("v%0d_maddr%0d", k, i), 64'(mq[base+i].a), 64'(v.w[i]));
         chk($sformatf("v%0d_mwe%0d", k, i), 64'(mq[base+i].we), 64'(v.wr));
         if (v.wr) begin
            chk($sformatf("v%0d_mwdata%0d", k, i), mq[base+i].d, v.d[i]);
            chk($sformatf("v%0d_mwstrb%0d", k, i), 64'(mq[base+i].s), 64'(i[0] ? v.s1 : v.s0));
         end
      end
   endtask

   logic [63:0] last800 = '0;

   // Both channels valid at once; the first grant must follow the priority pointer.
   task automatic contend(input int r, input bit exp_wr_first);
      vec_t wv, rv;
      bit   got = 1'b0, wr_first = 1'b0;
      logic [63:0] dw = 64'hC0DE_0000_0000_0000 + 64'(r);
      wv = mk(1, 10'(16 + r), 64'h800, 0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1,
              256, 0, 0, 0, dw, 0, 0, 0);
      rv = mk(0, 10'(32 + r), 64'h800, 0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1,
              256, 0, 0, 0, exp_wr_first ? dw : last800, 0, 0, 0);
      last800 = dw;
      set_aw(wv); set_ar(rv);
      awvalid = 1'b1; arvalid = 1'b1;
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         got = awready || arready;
         wr_first = awready;
         if (got) chk("single_grant", 64'(awready && arready), 64'd0);
      end
      chk($sformatf("grant_round%0d", r), 64'(wr_first), 64'(exp_wr_first));
      @(posedge clk); #1;
      if (wr_first) begin
         awvalid = 1'b0;
         w_phase(wv);
         wait_hi(1, "arready");
         @(posedge clk); #1 arvalid = 1'b0;
         r_phase(rv);
      end else begin
         arvalid = 1'b0;
         r_phase(rv);
         wait_hi(0, "awready");
         @(posedge clk); #1 awvalid = 1'b0;
         w_phase(wv);
      end
   endtask

   vec_t vecs[18];

   initial begin
      vecs[0]  = mk(1, 1,      64'h40,    0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1, 8, 0, 0, 0,
                    64'h1122334455667788, 0, 0, 0);
      vecs[1]  = mk(0, 2,      64'h40,    0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1, 8, 0, 0, 0,
                    64'h1122334455667788, 0, 0, 0);
      vecs[2]  = mk(1, 3,      64'h100,   3, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 4, 32, 33, 34, 35,
                    64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                    64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004);
      vecs[3]  = mk(0, 10'h155, 64'h100,  3, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 4, 32, 33, 34, 35,
                    64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                    64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004);
      vecs[4]  = mk(1, 4,      64'h0,     3, 2, 2'b01, 8'h0F, 8'hF0, 0, 2'b00, 4, 0, 0, 1, 1,
                    64'h0000_0000_1111_1111, 64'h2222_2222_0000_0000,
                    64'h0000_0000_3333_3333, 64'h4444_4444_0000_0000);
      vecs[5]  = mk(0, 5,      64'h0,     1, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 2, 0, 1, 0, 0,
                    64'h2222_2222_1111_1111, 64'h4444_4444_3333_3333, 0, 0);
      vecs[6]  = mk(1, 6,      64'h200,   3, 3, 2'b00, 8'hFF, 8'hFF, 0, 2'b00, 4, 64, 64, 64, 64,
                    1, 2, 3, 4);
      vecs[7]  = mk(0, 7,      64'h200,   1, 3, 2'b00, 8'hFF, 8'hFF, 0, 2'b00, 2, 64, 64, 0, 0,
                    4, 4, 0, 0);
      vecs[8]  = mk(1, 8,      64'h300,   1, 3, 2'b10, 8'hFF, 8'hFF, 0, 2'b10, 0, 0, 0, 0, 0,
                    5, 6, 0, 0);
      vecs[9]  = mk(0, 9,      64'h8000,  0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b11, 0, 0, 0, 0, 0,
                    0, 0, 0, 0);
      vecs[10] = mk(1, 10,     64'h7FF8,  1, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 2, 4095, 0, 0, 0,
                    7, 8, 0, 0);
      vecs[11] = mk(0, 11,     64'h0,     0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1, 0, 0, 0, 0,
                    8, 0, 0, 0);
      vecs[12] = mk(0, 12,     64'h7FF8,  0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 1, 4095, 0, 0, 0,
                    7, 0, 0, 0);
      vecs[13] = mk(1, 13,     64'h10000, 0, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b11, 0, 0, 0, 0, 0,
                    9, 0, 0, 0);
      vecs[14] = mk(1, 14,     64'h400,   1, 3, 2'b01, 8'hFF, 8'hFF, 1, 2'b10, 2, 128, 129, 0, 0,
                    10, 11, 0, 0);
      vecs[15] = mk(0, 15,     64'h400,   1, 3, 2'b01, 8'hFF, 8'hFF, 0, 2'b00, 2, 128, 129, 0, 0,
                    10, 11, 0, 0);
      vecs[16] = mk(1, 16,     64'h0,     0, 3, 2'b11, 8'hFF, 8'hFF, 0, 2'b10, 0, 0, 0, 0, 0,
                    12, 0, 0, 0);
      vecs[17] = mk(0, 17,     64'h0,     1, 3, 2'b10, 8'hFF, 8'hFF, 0, 2'b10, 0, 0, 0, 0, 0,
                    0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_awready", 64'(awready), 0);
      chk("rst_arready", 64'(arready), 0);
      chk("rst_wready",  64'(wready), 0);
      chk("rst_bvalid",  64'(bvalid), 0);
      chk("rst_rvalid",  64'(rvalid), 0);
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_rlast",   64'(rlast), 0);
      chk("rst_bresp",   64'(bresp), 0);
      chk("rst_rresp",   64'(rresp), 0);
      @(posedge clk); #1;

      contend(0, 1'b1);
      contend(1, 1'b0);
      contend(2, 1'b1);

      for (int k = 0; k < 18; k++) run_vec(vecs[k], k);

      // Reset in the middle of beat 2 of a 4-beat read.
      begin
         int base;
         set_ar(vecs[3]); arvalid = 1'b1;
         wait_hi(1, "arready");
         @(posedge clk); #1 arvalid = 1'b0;
         wait_hi(4, "rvalid");
         chk("mid_rdata0", rdata, vecs[3].d[0]);
         @(posedge clk); #1 rready = 1'b1;
         @(posedge clk); #1 rready = 1'b0;
         wait_hi(4, "rvalid");
         chk("mid_rdata1", rdata, vecs[3].d[1]);
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("mid_rst_rvalid", 64'(rvalid), 0);
         chk("mid_rst_rlast", 64'(rlast), 0);
         chk("mid_rst_mem_req", 64'(mem_req), 0);
         base = mq.size();
         @(posedge clk); #1 rst = 1'b0;
         repeat (4) @(negedge clk);
         chk("post_rst_rvalid", 64'(rvalid), 0);
         chk("post_rst_bvalid", 64'(bvalid), 0);
         chk("post_rst_noreq", 64'(mq.size() - base), 0);
         @(posedge clk); #1;
      end

      contend(3, 1'b1);
      run_vec(vecs[0], 100);
      run_vec(vecs[1], 101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
